// File: rtl/dmem_ctrl_if.sv
// Data-port bundle between the memory stage (master) and dmem_ctrl (slave).
// mem_be is present only when DMEM_BYTE_EN_EN is defined.
interface dmem_ctrl_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  mem_be;
`endif
  logic        mem_valid;
  logic [31:0] mem_read_data;
  logic        mem_err;
  logic        busy;

  modport master (
`ifdef DMEM_BYTE_EN_EN
    output mem_be,
`endif
    output mem_req, mem_write, mem_addr, mem_write_data,
    input  mem_valid, mem_read_data, mem_err, busy
  );

  modport slave (
`ifdef DMEM_BYTE_EN_EN
    input  mem_be,
`endif
    input  mem_req, mem_write, mem_addr, mem_write_data,
    output mem_valid, mem_read_data, mem_err, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store at a time, WAIT_STATES-cycle latency, fault flagging.
// Optional byte-enable stores when DMEM_BYTE_EN_EN is defined.
module dmem_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            req_write;
  logic [31:0]     req_addr;
  logic [31:0]     req_data;
  logic [3:0]      req_be;
  logic [3:0]      be_in;
  logic [31:0]     mem [DEPTH];

  logic            commit;
  logic            c_write;
  logic [31:0]     c_addr;
  logic [31:0]     c_data;
  logic [3:0]      c_be;
  logic            c_fault;
  logic [AW-1:0]   c_idx;

`ifdef DMEM_BYTE_EN_EN
  assign be_in = bus.mem_be;
`else
  assign be_in = 4'hF;
`endif

  // With no wait states the access commits on its capture edge, so it uses the live bus.
  always_comb begin
    commit  = 1'b0;
    c_write = req_write;
    c_addr  = req_addr;
    c_data  = req_data;
    c_be    = req_be;
    case (state)
      IDLE: begin
        if (WAIT_STATES == 0 && bus.mem_req) begin
          commit  = 1'b1;
          c_write = bus.mem_write;
          c_addr  = bus.mem_addr;
          c_data  = bus.mem_write_data;
          c_be    = be_in;
        end
      end
      BUSY:    commit = (cnt == CW'(1));
      default: commit = 1'b0;
    endcase
    commit  = commit && !rst;
    c_fault = (c_addr[1:0] != 2'b00) || ({1'b0, c_addr} >= LIMIT);
    c_idx   = c_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (commit && c_write && !c_fault) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (c_be[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      req_write         <= 1'b0;
      req_addr          <= '0;
      req_data          <= '0;
      req_be            <= '0;
      bus.mem_valid     <= 1'b0;
      bus.mem_read_data <= '0;
      bus.mem_err       <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            req_write <= bus.mem_write;
            req_addr  <= bus.mem_addr;
            req_data  <= bus.mem_write_data;
            req_be    <= be_in;
            cnt       <= CW'(WAIT_STATES);
            bus.busy  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state             <= RESP;
              bus.mem_valid     <= 1'b1;
              bus.mem_err       <= c_fault;
              bus.mem_read_data <= (c_write || c_fault) ? '0 : mem[c_idx];
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            state             <= RESP;
            bus.mem_valid     <= 1'b1;
            bus.mem_err       <= c_fault;
            bus.mem_read_data <= (c_write || c_fault) ? '0 : mem[c_idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state             <= IDLE;
          bus.mem_valid     <= 1'b0;
          bus.mem_err       <= 1'b0;
          bus.mem_read_data <= '0;
          bus.busy          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: WAIT_STATES=2/DEPTH=1024 and WAIT_STATES=0/DEPTH=16 instances
// against a word-array reference model; byte enables exercised when DMEM_BYTE_EN_EN is defined.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dmem_ctrl_if b0 ();
  dmem_ctrl_if b1 ();

  dmem_ctrl #(.DEPTH(1024), .WAIT_STATES(2)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dmem_ctrl #(.DEPTH(16),   .WAIT_STATES(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic [31:0] m0 [1024];
  logic [31:0] m1 [16];
  int lv [2] = '{-100, -100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] o_valid(input int sel);
    return sel == 1 ? 32'(b1.mem_valid) : 32'(b0.mem_valid);
  endfunction
  function automatic logic [31:0] o_busy(input int sel);
    return sel == 1 ? 32'(b1.busy) : 32'(b0.busy);
  endfunction
  function automatic logic [31:0] o_err(input int sel);
    return sel == 1 ? 32'(b1.mem_err) : 32'(b0.mem_err);
  endfunction
  function automatic logic [31:0] o_rdata(input int sel);
    return sel == 1 ? b1.mem_read_data : b0.mem_read_data;
  endfunction

  task automatic drive(input int sel, input bit req, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (sel == 1) begin
      b1.mem_req = req; b1.mem_write = wr; b1.mem_addr = a; b1.mem_write_data = d;
`ifdef DMEM_BYTE_EN_EN
      b1.mem_be = be;
`endif
    end else begin
      b0.mem_req = req; b0.mem_write = wr; b0.mem_addr = a; b0.mem_write_data = d;
`ifdef DMEM_BYTE_EN_EN
      b0.mem_be = be;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access; expected timing: capture on the first edge the controller is idle
  // (>= two edges after the previous pulse), pulse WAIT_STATES edges after that.
  task automatic access(input int sel, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int gap, output logic [31:0] obs);
    int          ws, depth, cap, vexp;
    bit          fault;
    logic [31:0] word, exp_rd;
    logic [3:0]  be_eff;
    ws    = (sel == 1) ? 0 : 2;
    depth = (sel == 1) ? 16 : 1024;
    fault = ((a % 4) != 0) || (longint'({32'd0, a}) >= longint'(depth) * 4);
    word  = '0;
    if (!fault) word = (sel == 1) ? m1[a / 4] : m0[a / 4];
    exp_rd = (!wr && !fault) ? word : 32'd0;
`ifdef DMEM_BYTE_EN_EN
    be_eff = be;
`else
    be_eff = 4'hF;
`endif
    if (wr && !fault) begin
      for (int b = 0; b < 4; b++) if (be_eff[b]) word[8*b +: 8] = d[8*b +: 8];
      if (sel == 1) m1[a / 4] = word; else m0[a / 4] = word;
    end
    drive(sel, 1'b1, wr, a, d, be);
    cap  = (cyc + 1 > lv[sel] + 2) ? cyc + 1 : lv[sel] + 2;
    vexp = cap + ws;
    while (cyc < vexp) begin
      tick();
      chk($sformatf("u%0d_valid@%0d", sel, cyc), o_valid(sel), 32'(cyc == vexp));
      chk($sformatf("u%0d_busy@%0d", sel, cyc), o_busy(sel), 32'(cyc >= cap));
    end
    chk($sformatf("u%0d_err a=%h", sel, a), o_err(sel), 32'(fault));
    chk($sformatf("u%0d_rdata a=%h", sel, a), o_rdata(sel), exp_rd);
    obs = o_rdata(sel);
    lv[sel] = cyc;
    if (gap > 0) begin
      if (sel == 1) b1.mem_req = 1'b0; else b0.mem_req = 1'b0;
      repeat (gap) tick();
    end
  endtask

  function automatic logic [31:0] rand_addr(input int depth);
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 32'($urandom_range(0, (depth < 32 ? depth : 32) - 1) * 4);
    if (r == 7) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
    if (r == 8) return 32'(depth * 4 + $urandom_range(0, 50) * 4);
    return 32'hFFFF_FFFC;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs, pre;
    logic [3:0]  be;
    drive(0, 1'b0, 1'b0, '0, '0, 4'h0);
    drive(1, 1'b0, 1'b0, '0, '0, 4'h0);
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", o_valid(0), 32'd0);
      chk("idle_err",   o_err(0),   32'd0);
      chk("idle_busy",  o_busy(0),  32'd0);
      chk("idle_rdata", o_rdata(0), 32'd0);
      chk("idle_valid1", o_valid(1), 32'd0);
    end

    for (int k = 0; k < 32; k++) access(0, 1'b1, 32'(k * 4), $urandom, 4'hF, 1, obs);
    for (int k = 0; k < 16; k++) access(1, 1'b1, 32'(k * 4), $urandom, 4'hF, 1, obs);

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, obs);
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, obs);
    chk("ws2_load_0x10", obs, 32'hDEADBEEF);

    access(0, 1'b1, 32'h13, 32'h0BAD_0BAD, 4'hF, 1, obs);
    access(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0, obs);
    access(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1, obs);
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, obs);
    chk("after_fault_0x10", obs, 32'hDEADBEEF);

    pre = m0[8];
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555, 4'hF);
    tick();
    tick();
    chk("abort_busy_before", o_busy(0), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_valid", o_valid(0), 32'd0);
    chk("abort_busy",  o_busy(0),  32'd0);
    chk("abort_err",   o_err(0),   32'd0);
    chk("abort_rdata", o_rdata(0), 32'd0);
    tick();
    rst = 1'b0;
    b0.mem_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_valid", o_valid(0), 32'd0);
    end
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, 1, obs);
    chk("abort_keeps_0x20", obs, pre);

`ifdef DMEM_BYTE_EN_EN
    access(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 1, obs);
    access(0, 1'b1, 32'h8, 32'h11223344, 4'b0101, 1, obs);
    access(0, 1'b0, 32'h8, 32'h0, 4'h0, 1, obs);
    chk("be_merge_0x8", obs, 32'hFF22FF44);
`endif

    access(1, 1'b1, 32'h0, 32'h12345678, 4'hF, 0, obs);
    access(1, 1'b0, 32'h0, 32'h0, 4'hF, 1, obs);
    chk("ws0_load_0x0", obs, 32'h12345678);
    tick();
    chk("ws0_busy_drop", o_busy(1), 32'd0);
    access(1, 1'b0, 32'h40, 32'h0, 4'hF, 1, obs);

    for (int i = 0; i < 60; i++) begin
      be = 4'($urandom_range(0, 15));
      access(0, 1'($urandom_range(0, 1)), rand_addr(1024), $urandom, be, $urandom_range(0, 2), obs);
    end
    for (int i = 0; i < 30; i++) begin
      be = 4'($urandom_range(0, 15));
      access(1, 1'($urandom_range(0, 1)), rand_addr(16), $urandom, be, $urandom_range(0, 2), obs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
